fir_tap_sequencer: RTL

Sequences one FIR output per audio sample: accepts a sample into a circular delay line, steps `tapnum` through all taps of the coefficient generator, multiply-accumulates each returned `tapcoeff` against the matching delayed sample, then emits one saturated result. It sits between the audio sample source and the DAC-side output path, and is the only driver of the coefficient generator's tap index and EQ selection.

---
 rtl/fir_tap_sequencer_if.sv | 25 ++
 rtl/fir_tap_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fir_tap_sequencer_if.sv
// Sample handshake, coefficient generator and filter result signals of fir_tap_sequencer.
interface fir_tap_sequencer_if;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic [7:0]  eqVal;
  logic [7:0]  eqSel;
  logic [7:0]  tapnum;
  logic [15:0] tapcoeff;
  logic [15:0] filt_out;
  logic        filt_valid;
  logic        busy;

  // Sequencer side
  modport slave (
    input  sample_in, sample_valid, eqVal, tapcoeff,
    output sample_ready, eqSel, tapnum, filt_out, filt_valid, busy
  );

  // Sample source / coefficient generator / output path side
  modport master (
    output sample_in, sample_valid, eqVal, tapcoeff,
    input  sample_ready, eqSel, tapnum, filt_out, filt_valid, busy
  );
endinterface

// File: rtl/fir_tap_sequencer.sv
// One FIR output per accepted sample: circular delay line, tap sequencing,
// multiply-accumulate against a latency-matched coefficient stream, saturated result.
module fir_tap_sequencer #(
  parameter int unsigned NTAPS    = 32,
  parameter int unsigned COEF_LAT = 1,
  parameter int unsigned ACCW     = 40
) (
  input  logic                 clk,
  input  logic                 reset,
  fir_tap_sequencer_if.slave   bus
);

  localparam int unsigned PW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam int unsigned PL = (COEF_LAT > 0) ? COEF_LAT : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           wptr_q, wptr_d;
  logic [7:0]              tapnum_q, tapnum_d;
  logic [7:0]              eqsel_q, eqsel_d;
  logic signed [ACCW-1:0]  acc_q, acc_d;
  logic [15:0]             filt_out_q, filt_out_d;
  logic                    filt_valid_q, filt_valid_d;
  logic                    sample_ready_q, sample_ready_d;
  logic                    busy_q, busy_d;
  logic [1:0]              dcnt_q, dcnt_d;
  logic signed [15:0]      dline_q [NTAPS];
  logic signed [15:0]      dline_d [NTAPS];
  logic signed [15:0]      pipe_samp_q [PL];
  logic signed [15:0]      pipe_samp_d [PL];
  logic [PL-1:0]           pipe_vld_q, pipe_vld_d;

  logic [PW-1:0]           k;
  logic [PW-1:0]           rd_idx;
  logic signed [15:0]      rd_samp;
  logic                    run;
  logic signed [15:0]      tap_samp;
  logic                    tap_vld;
  logic signed [31:0]      prod;
  logic signed [ACCW-1:0]  shifted;
  logic [ACCW-16:0]        hi;
  logic [15:0]             sat_res;

  assign run = (state_q == RUN);
  assign k   = tapnum_q[PW-1:0];

  // Delay-line read for the current tap: (wptr - k) mod NTAPS
  always_comb begin
    if (wptr_q >= k) rd_idx = wptr_q - k;
    else             rd_idx = PW'({1'b0, wptr_q} + (PW+1)'(NTAPS) - {1'b0, k});
    rd_samp = dline_q[rd_idx];
  end

  // Align the delayed sample and its valid bit with the coefficient return
  generate
    if (COEF_LAT == 0) begin : g_nolat
      assign tap_samp = rd_samp;
      assign tap_vld  = run;
    end else begin : g_lat
      assign tap_samp = pipe_samp_q[COEF_LAT-1];
      assign tap_vld  = pipe_vld_q[COEF_LAT-1];
    end
  endgenerate

  // Sample pipeline shift
  always_comb begin
    pipe_samp_d[0] = rd_samp;
    pipe_vld_d     = '0;
    pipe_vld_d[0]  = run;
    for (int i = 1; i < int'(PL); i++) begin
      pipe_samp_d[i] = pipe_samp_q[i-1];
      pipe_vld_d[i]  = pipe_vld_q[i-1];
    end
  end

  // Next-state, accumulate and result saturation
  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    tapnum_d     = tapnum_q;
    eqsel_d      = eqsel_q;
    dline_d      = dline_q;
    dcnt_d       = dcnt_q;
    filt_out_d   = filt_out_q;
    filt_valid_d = 1'b0;

    prod  = 32'(tap_samp) * 32'($signed(bus.tapcoeff));
    acc_d = acc_q;
    if (tap_vld) acc_d = acc_q + ACCW'(prod);

    case (state_q)
      IDLE: begin
        if (bus.sample_valid) begin
          dline_d[wptr_q] = $signed(bus.sample_in);
          eqsel_d         = bus.eqVal;
          acc_d           = '0;
          tapnum_d        = '0;
          state_d         = RUN;
        end
      end
      RUN: begin
        if (tapnum_q == 8'(NTAPS - 1)) begin
          dcnt_d  = '0;
          state_d = (COEF_LAT == 0) ? DONE : DRAIN;
        end else begin
          tapnum_d = tapnum_q + 8'd1;
        end
      end
      DRAIN: begin
        if (dcnt_q == 2'(COEF_LAT - 1)) state_d = DONE;
        else                            dcnt_d  = dcnt_q + 2'd1;
      end
      DONE: begin
        wptr_d  = (wptr_q == PW'(NTAPS - 1)) ? '0 : wptr_q + PW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Result uses the accumulator including the final product of this cycle
    shifted = acc_d >>> 15;
    hi      = shifted[ACCW-1:15];
    if ((&hi) || !(|hi)) sat_res = shifted[15:0];
    else                 sat_res = shifted[ACCW-1] ? 16'h8000 : 16'h7FFF;
    if (state_d == DONE && state_q != DONE) begin
      filt_out_d   = sat_res;
      filt_valid_d = 1'b1;
    end

    sample_ready_d = (state_d == IDLE);
    busy_d         = (state_d != IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      wptr_q         <= '0;
      tapnum_q       <= '0;
      eqsel_q        <= '0;
      acc_q          <= '0;
      filt_out_q     <= '0;
      filt_valid_q   <= 1'b0;
      sample_ready_q <= 1'b1;
      busy_q         <= 1'b0;
      dcnt_q         <= '0;
      pipe_vld_q     <= '0;
      for (int i = 0; i < int'(NTAPS); i++) dline_q[i] <= '0;
      for (int i = 0; i < int'(PL); i++) pipe_samp_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      wptr_q         <= wptr_d;
      tapnum_q       <= tapnum_d;
      eqsel_q        <= eqsel_d;
      acc_q          <= acc_d;
      filt_out_q     <= filt_out_d;
      filt_valid_q   <= filt_valid_d;
      sample_ready_q <= sample_ready_d;
      busy_q         <= busy_d;
      dcnt_q         <= dcnt_d;
      pipe_vld_q     <= pipe_vld_d;
      for (int i = 0; i < int'(NTAPS); i++) dline_q[i] <= dline_d[i];
      for (int i = 0; i < int'(PL); i++) pipe_samp_q[i] <= pipe_samp_d[i];
    end
  end

  assign bus.sample_ready = sample_ready_q;
  assign bus.busy         = busy_q;
  assign bus.tapnum       = tapnum_q;
  assign bus.eqSel        = eqsel_q;
  assign bus.filt_out     = filt_out_q;
  assign bus.filt_valid   = filt_valid_q;

endmodule
